mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one iterative multiplier (start pulse, combinational stall, 2*width product) between two requesters, e.g. the integer pipe and the coprocessor/debug port.
- Round-robin arbitration, per-requester valid/ready request and response channels, and low/high-half product selection.
- A one-entry operand cache lets a high/low pair on the same operands (MULH followed by MUL) cost one multiply.

Parameters:
- width, 32, operand width; product is 2*width.
- DRAIN_CYCLES, 2*width+2, cycles after reset before the first issue, so an unreset multiplier can finish.
- CACHE_EN, 1, enables the operand/result cache (0 = every request issues).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0Valid/req1Valid  in  1  request present.
- req0Ready/req1Ready  out  1  request accepted this cycle.
- req0Src1/req1Src1, req0Src2/req1Src2  in  width  operands.
- req0Signed/req1Signed  in  1  1 = signed x signed.
- req0High/req1High  in  1  1 = return product[2w-1:w], 0 = product[w-1:0].
- rsp0Valid/rsp1Valid  out  1  response valid.
- rsp0Ready/rsp1Ready  in  1  response consumed.
- rsp0Data/rsp1Data  out  width  selected product half.
- multBegin  out  1  one-cycle start pulse to the multiplier.
- isSigned  out  1  latched signed flag.
- multSrc1, multSrc2  out  width  latched operands, held stable from ISSUE through WAIT.
- multStall  in  1  multiplier stall (goes high in the start cycle, low when the product is ready).
- multOut  in  2*width  multiplier product.

Behaviour:
- Reset values: all ready/valid outputs 0, multBegin 0, rsp data 0, isSigned 0, multSrc 0, cache invalid, RR pointer favours requester 0. State goes to FLUSH, drain counter = 0.
- States: FLUSH, IDLE, ISSUE, WAIT, RESP.
- FLUSH: counter increments every cycle; no reqReady. Go to IDLE when the counter reaches DRAIN_CYCLES-1.
- IDLE grant:
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last.
  - reqNReady=1 combinationally in IDLE for the granted requester only.
  - On acceptance: latch operands, signed, high, grant id; update the RR pointer.
- IDLE next state: cache hit (CACHE_EN, cache valid, src1, src2 and signed all equal) goes to RESP with the cached product. Otherwise go to ISSUE.
- ISSUE: multBegin=1 for exactly this cycle, then go to WAIT. The multiplier raises multStall in this same cycle; it is ignored here.
- WAIT: multBegin=0. When multStall==0 is sampled, capture multOut into the result register and the cache (operands + signed + product, valid=1), then go to RESP.
- RESP:
  - rspNValid=1 for the granted id only.
  - rspNData = high ? product[2w-1:w] : product[w-1:0].
  - Data is held stable while rspNReady=0.
  - On rspNReady=1, go to IDLE next cycle; the other requester may be granted in that IDLE cycle.
- Latency:
  - Cache hit: accept to rspValid = 1 cycle.
  - Miss: ISSUE + WAIT (about 2*width+1 cycles with the 64-iteration unit) + 1.
  - The multiplier's one-cycle busy tail has cleared before the next ISSUE can occur.
- Only one request is in flight; the non-granted requester sees reqReady=0 until the next IDLE.
- A request held valid across RESP is re-arbitrated in IDLE; no request is dropped or duplicated.
- Reset mid-operation (any state): all outputs are cleared immediately on the next edge, the cache is invalidated, and the block enters FLUSH. The in-flight response is lost.
- reqValid in FLUSH is ignored (not accepted). reqNSrc changes while reqNReady=0 have no effect.

Test Plan:
- Reset, req0Valid=1 from cycle 0 (7*6, unsigned, low) -> req0Ready stays 0 for DRAIN_CYCLES=66 cycles, then the request is accepted; one multBegin pulse; rsp0Data=42.
- req1: src1=0xFFFFFFFD (-3), src2=5, signed, high -> rsp1Data=0xFFFFFFFF. Then the same operands with high=0 -> rsp1Data=0xFFFFFFF1 exactly 1 cycle after acceptance, with no multBegin.
- req0 and req1 valid in the same cycle (0x10000*0x10000 unsigned high; 3*4 low) -> req0 granted first with rsp0Data=0x1; then req1 with rsp1Data=12; two multBegin pulses total.
- rsp0Ready=0 for 10 cycles after rsp0Valid -> rsp0Valid and rsp0Data held constant; req1 (valid throughout) not accepted until the cycle after rsp0Ready=1.
- Same operands with signed flipped (0xFFFFFFFF*2, first signed then unsigned, low) -> second is a cache miss with a new multBegin; results 0xFFFFFFFE both, high halves differ if requested (0xFFFFFFFF vs 0x1).
- Assert rst for 1 cycle mid-WAIT -> multBegin/rsp/ready all 0 next cycle; FLUSH of 66 cycles; the previously cached operand pair now misses and issues multBegin.

Source files
------------

// File: rtl/mult_arbiter.sv
// ============================================================================
// mult_arbiter: round-robin share of one iterative multiplier between two
// requesters, with a one-entry operand/product cache.   Rev 1.0
// ============================================================================
`default_nettype none

module mult_arbiter #(
  parameter int width        = 32,
  parameter int DRAIN_CYCLES = 2*width+2,
  parameter bit CACHE_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0Valid,
  input  logic               req1Valid,
  output logic               req0Ready,
  output logic               req1Ready,
  input  logic [width-1:0]   req0Src1,
  input  logic [width-1:0]   req0Src2,
  input  logic [width-1:0]   req1Src1,
  input  logic [width-1:0]   req1Src2,
  input  logic               req0Signed,
  input  logic               req1Signed,
  input  logic               req0High,
  input  logic               req1High,
  output logic               rsp0Valid,
  output logic               rsp1Valid,
  input  logic               rsp0Ready,
  input  logic               rsp1Ready,
  output logic [width-1:0]   rsp0Data,
  output logic [width-1:0]   rsp1Data,
  output logic               multBegin,
  output logic               isSigned,
  output logic [width-1:0]   multSrc1,
  output logic [width-1:0]   multSrc2,
  input  logic               multStall,
  input  logic [2*width-1:0] multOut
);

  localparam int CW = $clog2(DRAIN_CYCLES+1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES-1);

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      drain_cnt;
  logic               rr_prio;
  logic               gnt_id;
  logic               high_q;
  logic [2*width-1:0] prod;
  logic               cache_vld;
  logic               cache_sgn;
  logic [width-1:0]   cache_src1;
  logic [width-1:0]   cache_src2;
  logic [2*width-1:0] cache_prod;

  logic               sel;
  logic               acc_valid;
  logic [width-1:0]   sel_src1;
  logic [width-1:0]   sel_src2;
  logic               sel_sgn;
  logic               sel_high;
  logic               cache_hit;
  logic               accept;
  logic [width-1:0]   rsp_half;

  // When both are valid the favoured one wins; otherwise whichever is valid.
  assign sel       = (req0Valid && req1Valid) ? rr_prio : !req0Valid;
  assign acc_valid = sel ? req1Valid  : req0Valid;
  assign sel_src1  = sel ? req1Src1   : req0Src1;
  assign sel_src2  = sel ? req1Src2   : req0Src2;
  assign sel_sgn   = sel ? req1Signed : req0Signed;
  assign sel_high  = sel ? req1High   : req0High;
  assign accept    = (state == S_IDLE) && acc_valid;

  if (CACHE_EN) begin : g_cache
    assign cache_hit = cache_vld && (cache_src1 == sel_src1) &&
                       (cache_src2 == sel_src2) && (cache_sgn == sel_sgn);
  end else begin : g_no_cache
    assign cache_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FLUSH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req0Ready = 1'b0;
    req1Ready = 1'b0;
    multBegin = 1'b0;
    rsp0Valid = 1'b0;
    rsp1Valid = 1'b0;
    case (state)
      S_FLUSH: if (drain_cnt == DRAIN_LAST) state_nxt = S_IDLE;
      S_IDLE: begin
        if (acc_valid) begin
          req0Ready = !sel;
          req1Ready = sel;
          state_nxt = cache_hit ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        multBegin = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (!multStall) state_nxt = S_RESP;
      S_RESP: begin
        rsp0Valid = !gnt_id;
        rsp1Valid = gnt_id;
        if (gnt_id ? rsp1Ready : rsp0Ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_FLUSH;
    endcase
  end

  assign rsp_half = high_q ? prod[2*width-1:width] : prod[width-1:0];
  assign rsp0Data = rsp0Valid ? rsp_half : '0;
  assign rsp1Data = rsp1Valid ? rsp_half : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt  <= '0;
      rr_prio    <= 1'b0;
      gnt_id     <= 1'b0;
      high_q     <= 1'b0;
      prod       <= '0;
      isSigned   <= 1'b0;
      multSrc1   <= '0;
      multSrc2   <= '0;
      cache_vld  <= 1'b0;
      cache_sgn  <= 1'b0;
      cache_src1 <= '0;
      cache_src2 <= '0;
      cache_prod <= '0;
    end else begin
      if (state == S_FLUSH && drain_cnt != DRAIN_LAST) drain_cnt <= drain_cnt + CW'(1);
      if (accept) begin
        multSrc1 <= sel_src1;
        multSrc2 <= sel_src2;
        isSigned <= sel_sgn;
        high_q   <= sel_high;
        gnt_id   <= sel;
        rr_prio  <= !sel;
        if (cache_hit) prod <= cache_prod;
      end
      // Operands stay latched in multSrc*, so they double as the cache tag.
      if (state == S_WAIT && !multStall) begin
        prod       <= multOut;
        cache_prod <= multOut;
        cache_src1 <= multSrc1;
        cache_src2 <= multSrc2;
        cache_sgn  <= isSigned;
        cache_vld  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ============================================================================
// tb_mult_arbiter: directed self-checking bench with a behavioural
// 64-cycle iterative multiplier.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_arbiter;

  localparam int W     = 32;
  localparam int DRAIN = 2*W+2;
  localparam int LAT   = 64;
  localparam int LIMIT = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0Valid = 1'b0, req1Valid = 1'b0;
  logic req0Ready, req1Ready;
  logic [W-1:0] req0Src1 = '0, req0Src2 = '0, req1Src1 = '0, req1Src2 = '0;
  logic req0Signed = 1'b0, req1Signed = 1'b0, req0High = 1'b0, req1High = 1'b0;
  logic rsp0Valid, rsp1Valid;
  logic rsp0Ready = 1'b0, rsp1Ready = 1'b0;
  logic [W-1:0] rsp0Data, rsp1Data;
  logic multBegin, isSigned, multStall;
  logic [W-1:0] multSrc1, multSrc2;
  logic [2*W-1:0] multOut;

  always #5 clk = ~clk;

  mult_arbiter #(.width(W), .DRAIN_CYCLES(DRAIN), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .req0Src1(req0Src1), .req0Src2(req0Src2),
    .req1Src1(req1Src1), .req1Src2(req1Src2),
    .req0Signed(req0Signed), .req1Signed(req1Signed),
    .req0High(req0High), .req1High(req1High),
    .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid),
    .rsp0Ready(rsp0Ready), .rsp1Ready(rsp1Ready),
    .rsp0Data(rsp0Data), .rsp1Data(rsp1Data),
    .multBegin(multBegin), .isSigned(isSigned),
    .multSrc1(multSrc1), .multSrc2(multSrc2),
    .multStall(multStall), .multOut(multOut)
  );

  // Iterative multiplier: stall rises with the start pulse, product valid when it drops.
  logic [6:0]     busy  = '0;
  logic [2*W-1:0] mprod = '0;
  logic [2*W-1:0] ea, eb;
  assign ea = isSigned ? {{W{multSrc1[W-1]}}, multSrc1} : {{W{1'b0}}, multSrc1};
  assign eb = isSigned ? {{W{multSrc2[W-1]}}, multSrc2} : {{W{1'b0}}, multSrc2};
  assign multStall = multBegin || (busy != '0);
  assign multOut   = mprod;

  always @(posedge clk) begin
    if (multBegin) begin
      busy  <= 7'(LAT);
      mprod <= ea * eb;
    end else if (busy != '0) begin
      busy <= busy - 7'd1;
    end
  end

  int nbeg = 0;
  always @(posedge clk) if (multBegin) nbeg <= nbeg + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit s, input bit h, output int waited);
    waited = 0;
    if (!id) begin
      req0Src1 = a; req0Src2 = b; req0Signed = s; req0High = h; req0Valid = 1'b1;
    end else begin
      req1Src1 = a; req1Src2 = b; req1Signed = s; req1High = h; req1Valid = 1'b1;
    end
    #1;
    while (!(id ? req1Ready : req0Ready) && waited < LIMIT) begin
      step();
      waited++;
    end
    if (waited >= LIMIT) check("accept_timeout", id ? req1Ready : req0Ready, 1);
    step();
    if (!id) req0Valid = 1'b0;
    else     req1Valid = 1'b0;
  endtask

  task automatic get_rsp(input bit id, input logic [W-1:0] exp, input string tag, output int lat);
    lat = 1;
    while (!(id ? rsp1Valid : rsp0Valid) && lat < LIMIT) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, id ? rsp1Valid : rsp0Valid, 1);
    check(tag, id ? rsp1Data : rsp0Data, exp);
    if (!id) rsp0Ready = 1'b1;
    else     rsp1Ready = 1'b1;
    step();
    rsp0Ready = 1'b0;
    rsp1Ready = 1'b0;
  endtask

  initial begin
    int w, lat, b;
    logic ok;
    logic [W-1:0] d0;

    // Reset values
    rst = 1'b1;
    step(); step();
    check("rst_ready0", req0Ready, 0);
    check("rst_rsp0v", rsp0Valid, 0);
    check("rst_rsp1v", rsp1Valid, 0);
    check("rst_rsp0d", rsp0Data, 0);
    check("rst_begin", multBegin, 0);
    check("rst_signed", isSigned, 0);
    check("rst_src1", multSrc1, 0);

    // Drain window then 7*6
    rst = 1'b0;
    b = nbeg;
    send(0, 32'd7, 32'd6, 0, 0, w);
    check("drain_wait", w, DRAIN);
    get_rsp(0, 32'd42, "mul_7x6", lat);
    check("begins_7x6", nbeg - b, 1);

    // Signed high then cached low
    b = nbeg;
    send(1, 32'hFFFF_FFFD, 32'd5, 1, 1, w);
    get_rsp(1, 32'hFFFF_FFFF, "mulh_m3x5", lat);
    send(1, 32'hFFFF_FFFD, 32'd5, 1, 0, w);
    get_rsp(1, 32'hFFFF_FFF1, "mul_m3x5_hit", lat);
    check("hit_latency", lat, 1);
    check("begins_hit", nbeg - b, 1);

    // Simultaneous requests
    b = nbeg;
    req1Src1 = 32'd3; req1Src2 = 32'd4; req1Signed = 1'b0; req1High = 1'b0; req1Valid = 1'b1;
    send(0, 32'h0001_0000, 32'h0001_0000, 0, 1, w);
    check("both_grant0_wait", w, 0);
    check("both_req1_blocked", req1Ready, 0);
    get_rsp(0, 32'h1, "mulh_64k", lat);
    send(1, 32'd3, 32'd4, 0, 0, w);
    check("both_grant1_wait", w, 0);
    get_rsp(1, 32'd12, "mul_3x4", lat);
    check("begins_both", nbeg - b, 2);

    // Response back-pressure with req1 waiting
    req1Src1 = 32'd5; req1Src2 = 32'd5; req1Signed = 1'b0; req1High = 1'b0; req1Valid = 1'b1;
    send(0, 32'd2, 32'd3, 0, 0, w);
    lat = 0;
    while (!rsp0Valid && lat < LIMIT) begin
      check("bp_req1_blocked", req1Ready, 0);
      step();
      lat++;
    end
    d0 = rsp0Data;
    check("bp_data", d0, 32'd6);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp0Valid === 1'b1 && rsp0Data === d0 && req1Ready === 1'b0)) ok = 1'b0;
      step();
    end
    check("bp_hold", ok, 1);
    rsp0Ready = 1'b1;
    step();
    rsp0Ready = 1'b0;
    check("bp_req1_ready_after", req1Ready, 1);
    send(1, 32'd5, 32'd5, 0, 0, w);
    check("bp_req1_wait", w, 0);
    get_rsp(1, 32'd25, "mul_5x5", lat);

    // Signedness is part of the cache tag
    b = nbeg;
    send(0, 32'hFFFF_FFFF, 32'd2, 1, 0, w);
    get_rsp(0, 32'hFFFF_FFFE, "mul_s_m1x2", lat);
    send(0, 32'hFFFF_FFFF, 32'd2, 0, 0, w);
    get_rsp(0, 32'hFFFF_FFFE, "mul_u_m1x2", lat);
    check("begins_sign_flip", nbeg - b, 2);
    send(0, 32'hFFFF_FFFF, 32'd2, 0, 1, w);
    get_rsp(0, 32'h1, "mulhu_m1x2", lat);
    send(0, 32'hFFFF_FFFF, 32'd2, 1, 1, w);
    get_rsp(0, 32'hFFFF_FFFF, "mulh_s_m1x2", lat);
    check("begins_sign_all", nbeg - b, 3);

    // Reset mid-WAIT
    send(1, 32'd9, 32'd9, 0, 0, w);
    for (int i = 0; i < 5; i++) step();
    req0Src1 = 32'hFFFF_FFFF; req0Src2 = 32'd2; req0Signed = 1'b1; req0High = 1'b1; req0Valid = 1'b1;
    rst = 1'b1;
    step();
    check("midrst_begin", multBegin, 0);
    check("midrst_rsp1v", rsp1Valid, 0);
    check("midrst_ready0", req0Ready, 0);
    check("midrst_ready1", req1Ready, 0);
    rst = 1'b0;
    b = nbeg;
    send(0, 32'hFFFF_FFFF, 32'd2, 1, 1, w);
    check("midrst_drain", w, DRAIN);
    get_rsp(0, 32'hFFFF_FFFF, "midrst_mulh", lat);
    check("midrst_cache_miss", nbeg - b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
